// File: rtl/mac_rx_fcs_check.sv
// Receive MAC stage: CRC-32 residue check over every frame byte, FCS stripping
// through a one-word hold register, and a registered per-frame status strobe.

module mac_rx_fcs_check #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             valid_i,
  input  logic [31:0]      data_i,
  input  logic             last_i,
  input  logic [1:0]       len_i,
  input  logic             err_i,
  output logic             valid_o,
  output logic [31:0]      data_o,
  output logic             last_o,
  output logic [1:0]       len_o,
  output logic             done_o,
  output logic             fcs_ok_o,
  output logic             runt_o,
  output logic             oversize_o,
  output logic             abort_o,
  output logic             pcs_err_o,
  output logic [LEN_W-1:0] frame_len_o
);

  localparam logic [31:0]      CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0]      CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [LEN_W-1:0] MIN_L       = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L       = LEN_W'(MAX_LEN);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h00_0000, b};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) c = (c >> 1) ^ CRC_POLY;
      else      c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [31:0] crc_word(input logic [31:0] crc, input logic [31:0] d,
                                           input logic [2:0] nbytes);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < nbytes) c = crc_byte(c, d[8*i +: 8]);
      else                c = c;
    end
    return c;
  endfunction

  // Zero the lanes above len so stripped FCS bytes never leak onto data_o.
  function automatic logic [31:0] keep_bytes(input logic [31:0] d, input logic [1:0] len);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = (2'(i) <= len) ? d[8*i +: 8] : 8'h00;
    end
    return m;
  endfunction

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_crc, w_crc_nxt;
  logic [LEN_W-1:0] r_len, w_len_nxt;
  logic             r_err, w_err_nxt;
  logic [31:0]      r_hold, w_hold_nxt;

  logic             r_valid, w_valid_nxt;
  logic [31:0]      r_data, w_data_nxt;
  logic             r_last, w_last_nxt;
  logic [1:0]       r_olen, w_olen_nxt;
  logic             r_done, w_done_nxt;
  logic             r_fcs_ok, w_fcs_ok_nxt;
  logic             r_runt, w_runt_nxt;
  logic             r_over, w_over_nxt;
  logic             r_abort, w_abort_nxt;
  logic             r_pcs_err, w_pcs_err_nxt;
  logic [LEN_W-1:0] r_frame_len, w_frame_len_nxt;

  logic             w_new, w_accept, w_abort;
  logic [2:0]       w_nbytes;
  logic [31:0]      w_crc_base, w_crc_upd;
  logic [LEN_W-1:0] w_len_base, w_len_upd;
  logic [LEN_W:0]   w_len_sum;
  logic             w_err_upd;

  assign w_new      = valid_i & start_i;
  assign w_accept   = valid_i & (start_i | (r_state == ST_RUN));
  assign w_abort    = w_new & (r_state == ST_RUN);
  assign w_nbytes   = last_i ? ({1'b0, len_i} + 3'd1) : 3'd4;
  assign w_crc_base = w_new ? CRC_INIT : r_crc;
  assign w_crc_upd  = crc_word(w_crc_base, data_i, w_nbytes);
  assign w_len_base = w_new ? {LEN_W{1'b0}} : r_len;
  assign w_len_sum  = {1'b0, w_len_base} + {{(LEN_W-2){1'b0}}, w_nbytes};
  // Saturate so an absurdly long frame still reads as oversize.
  assign w_len_upd  = w_len_sum[LEN_W] ? {LEN_W{1'b1}} : w_len_sum[LEN_W-1:0];
  assign w_err_upd  = (w_new ? 1'b0 : r_err) | err_i;

  // Next-state, hold/output and status decode for one accepted word.
  always_comb begin
    w_state_nxt     = r_state;
    w_crc_nxt       = r_crc;
    w_len_nxt       = r_len;
    w_err_nxt       = r_err;
    w_hold_nxt      = r_hold;
    w_valid_nxt     = 1'b0;
    w_data_nxt      = 32'h0000_0000;
    w_last_nxt      = 1'b0;
    w_olen_nxt      = 2'd0;
    w_done_nxt      = 1'b0;
    w_fcs_ok_nxt    = 1'b0;
    w_runt_nxt      = 1'b0;
    w_over_nxt      = 1'b0;
    w_abort_nxt     = 1'b0;
    w_pcs_err_nxt   = 1'b0;
    w_frame_len_nxt = {LEN_W{1'b0}};
    if (w_accept) begin
      w_crc_nxt   = w_crc_upd;
      w_len_nxt   = w_len_upd;
      w_err_nxt   = w_err_upd;
      w_hold_nxt  = data_i;
      w_state_nxt = last_i ? ST_IDLE : ST_RUN;
      if (w_abort) begin
        // Old frame is cut short: report it, drop its held word.
        w_done_nxt      = 1'b1;
        w_abort_nxt     = 1'b1;
        w_pcs_err_nxt   = r_err;
        w_frame_len_nxt = r_len;
        w_runt_nxt      = (r_len < MIN_L);
        w_over_nxt      = (r_len > MAX_L);
      end else if (last_i) begin
        w_done_nxt      = 1'b1;
        w_fcs_ok_nxt    = (w_crc_upd == CRC_RESIDUE);
        w_runt_nxt      = (w_len_upd < MIN_L);
        w_over_nxt      = (w_len_upd > MAX_L);
        w_pcs_err_nxt   = w_err_upd;
        w_frame_len_nxt = w_len_upd;
        w_abort_nxt     = w_new & (len_i != 2'd3);
        if (!w_new) begin
          w_valid_nxt = 1'b1;
          w_last_nxt  = 1'b1;
          w_olen_nxt  = len_i;
          w_data_nxt  = keep_bytes(r_hold, len_i);
        end else begin
          w_valid_nxt = 1'b0;
        end
      end else if (!w_new) begin
        w_valid_nxt = 1'b1;
        w_olen_nxt  = 2'd3;
        w_data_nxt  = r_hold;
      end else begin
        w_valid_nxt = 1'b0;
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_crc       <= CRC_INIT;
      r_len       <= {LEN_W{1'b0}};
      r_err       <= 1'b0;
      r_hold      <= 32'h0000_0000;
      r_valid     <= 1'b0;
      r_data      <= 32'h0000_0000;
      r_last      <= 1'b0;
      r_olen      <= 2'd0;
      r_done      <= 1'b0;
      r_fcs_ok    <= 1'b0;
      r_runt      <= 1'b0;
      r_over      <= 1'b0;
      r_abort     <= 1'b0;
      r_pcs_err   <= 1'b0;
      r_frame_len <= {LEN_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_crc       <= w_crc_nxt;
      r_len       <= w_len_nxt;
      r_err       <= w_err_nxt;
      r_hold      <= w_hold_nxt;
      r_valid     <= w_valid_nxt;
      r_data      <= w_data_nxt;
      r_last      <= w_last_nxt;
      r_olen      <= w_olen_nxt;
      r_done      <= w_done_nxt;
      r_fcs_ok    <= w_fcs_ok_nxt;
      r_runt      <= w_runt_nxt;
      r_over      <= w_over_nxt;
      r_abort     <= w_abort_nxt;
      r_pcs_err   <= w_pcs_err_nxt;
      r_frame_len <= w_frame_len_nxt;
    end
  end

  assign valid_o     = r_valid;
  assign data_o      = r_data;
  assign last_o      = r_last;
  assign len_o       = r_olen;
  assign done_o      = r_done;
  assign fcs_ok_o    = r_fcs_ok;
  assign runt_o      = r_runt;
  assign oversize_o  = r_over;
  assign abort_o     = r_abort;
  assign pcs_err_o   = r_pcs_err;
  assign frame_len_o = r_frame_len;

endmodule

// File: tb/tb_mac_rx_fcs_check.sv
// Bench for mac_rx_fcs_check: byte-level frame model (table CRC, payload packing)
// against captured output words and status strobes.

module tb_mac_rx_fcs_check;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;
  localparam int LEN_W   = 16;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [1:0]  len;
  } word_t;
  typedef struct packed {
    logic        fcs_ok;
    logic        runt;
    logic        over;
    logic        abort;
    logic        pcs_err;
    logic        with_last;
    logic [15:0] flen;
    logic [1:0]  mode;   // 0 full check, 1 aborted frame, 2 sub-4-byte frame
  } stat_t;

  logic clk = 1'b0;
  logic reset, start_i, valid_i, last_i, err_i;
  logic [31:0] data_i;
  logic [1:0]  len_i;
  logic valid_o, last_o, done_o, fcs_ok_o, runt_o, oversize_o, abort_o, pcs_err_o;
  logic [31:0] data_o;
  logic [1:0]  len_o;
  logic [LEN_W-1:0] frame_len_o;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] crc_tab [256];
  word_t out_q[$], exp_q[$];
  stat_t st_q[$], exp_st[$];

  always #5 clk = ~clk;

  mac_rx_fcs_check #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .valid_i(valid_i), .data_i(data_i),
    .last_i(last_i), .len_i(len_i), .err_i(err_i), .valid_o(valid_o), .data_o(data_o),
    .last_o(last_o), .len_o(len_o), .done_o(done_o), .fcs_ok_o(fcs_ok_o), .runt_o(runt_o),
    .oversize_o(oversize_o), .abort_o(abort_o), .pcs_err_o(pcs_err_o), .frame_len_o(frame_len_o)
  );

  always @(negedge clk) begin
    if (valid_o === 1'b1) out_q.push_back({data_o, last_o, len_o});
    if (done_o === 1'b1)
      st_q.push_back({fcs_ok_o, runt_o, oversize_o, abort_o, pcs_err_o, last_o, frame_len_o, 2'b00});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_reg(input bq_t b, input int cnt);
    logic [31:0] c;
    logic [7:0]  idx;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < cnt; i++) begin
      idx = c[7:0] ^ b[i];
      c = crc_tab[idx] ^ (c >> 8);
    end
    return c;
  endfunction

  task automatic make_frame(input int n, input bit corrupt, output bq_t b);
    logic [31:0] fcs;
    int idx;
    b = {};
    if (n >= 4) begin
      for (int i = 0; i < n - 4; i++) b.push_back(8'($urandom));
      fcs = ~crc_reg(b, n - 4);
      for (int i = 0; i < 4; i++) b.push_back(fcs[8*i +: 8]);
    end else begin
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
    end
    if (corrupt && n > 0) begin
      idx = $urandom_range(0, n - 1);
      b[idx] = b[idx] ^ 8'(1 << $urandom_range(0, 7));
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic s, input logic l,
                       input logic [1:0] ln, input logic e, input int gap);
    for (int g = 0; g < gap; g++) begin
      valid_i = 1'b0; data_i = $urandom; start_i = 1'($urandom); last_i = 1'($urandom);
      err_i = 1'b0;
      @(posedge clk); #1;
    end
    valid_i = 1'b1; data_i = d; start_i = s; last_i = l; len_i = ln; err_i = e;
    @(posedge clk); #1;
    valid_i = 1'b0; start_i = 1'b0; last_i = 1'b0; err_i = 1'b0;
  endtask

  task automatic send_frame(input bq_t b, input int first_w, input int lim_w, input bit with_start,
                            input int gmin, input int gmax, input int err_w);
    int n, nw, gap;
    logic [31:0] d;
    logic isl;
    logic [1:0] ln;
    n  = b.size();
    nw = (n + 3) / 4;
    for (int k = first_w; k < nw && k < lim_w; k++) begin
      d = $urandom;
      for (int j = 0; j < 4; j++) if (4*k + j < n) d[8*j +: 8] = b[4*k + j];
      isl = (k == nw - 1);
      ln  = isl ? 2'((n - 1) % 4) : 2'd3;
      gap = (k == first_w) ? 0 : $urandom_range(gmin, gmax);
      drive(d, with_start && (k == first_w), isl, ln, k == err_w, gap);
    end
  endtask

  task automatic expect_partial(input bq_t b, input int nsent);
    word_t w;
    for (int k = 0; k < nsent - 1; k++) begin
      w.data = {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
      w.last = 1'b0;
      w.len  = 2'd3;
      exp_q.push_back(w);
    end
  endtask

  task automatic expect_abort(input bq_t b, input int nsent);
    stat_t s;
    expect_partial(b, nsent);
    s = '0;
    s.abort = 1'b1;
    s.mode  = 2'd1;
    exp_st.push_back(s);
  endtask

  task automatic expect_frame(input bq_t b, input bit err_any);
    int n, np, nwo;
    word_t w;
    stat_t s;
    n   = b.size();
    np  = (n >= 4) ? n - 4 : 0;
    nwo = (np + 3) / 4;
    for (int k = 0; k < nwo; k++) begin
      w.data = 32'h0;
      for (int j = 0; j < 4; j++) if (4*k + j < np) w.data[8*j +: 8] = b[4*k + j];
      w.last = (k == nwo - 1);
      w.len  = w.last ? 2'((np - 1) % 4) : 2'd3;
      exp_q.push_back(w);
    end
    s = '0;
    if (n >= 4) s.fcs_ok = ({b[n-1], b[n-2], b[n-3], b[n-4]} == ~crc_reg(b, np));
    s.runt      = (n < MIN_LEN);
    s.over      = (n > MAX_LEN);
    s.abort     = (n < 4);
    s.pcs_err   = err_any;
    s.with_last = (np > 0);
    s.flen      = 16'(n);
    s.mode      = (n < 4) ? 2'd2 : 2'd0;
    exp_st.push_back(s);
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ":out_count"}, 32'(out_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      chk({tag, ":out_data"}, out_q[i].data, exp_q[i].data);
      chk({tag, ":out_last"}, 32'(out_q[i].last), 32'(exp_q[i].last));
      if (exp_q[i].last) chk({tag, ":out_len"}, 32'(out_q[i].len), 32'(exp_q[i].len));
    end
    chk({tag, ":stat_count"}, 32'(st_q.size()), 32'(exp_st.size()));
    for (int i = 0; i < exp_st.size() && i < st_q.size(); i++) begin
      chk({tag, ":abort"}, 32'(st_q[i].abort), 32'(exp_st[i].abort));
      chk({tag, ":done_with_last"}, 32'(st_q[i].with_last), 32'(exp_st[i].with_last));
      if (exp_st[i].mode != 2'd2) chk({tag, ":fcs_ok"}, 32'(st_q[i].fcs_ok), 32'(exp_st[i].fcs_ok));
      if (exp_st[i].mode != 2'd1) chk({tag, ":frame_len"}, 32'(st_q[i].flen), 32'(exp_st[i].flen));
      if (exp_st[i].mode == 2'd0) begin
        chk({tag, ":runt"}, 32'(st_q[i].runt), 32'(exp_st[i].runt));
        chk({tag, ":oversize"}, 32'(st_q[i].over), 32'(exp_st[i].over));
        chk({tag, ":pcs_err"}, 32'(st_q[i].pcs_err), 32'(exp_st[i].pcs_err));
      end
    end
    out_q = {}; exp_q = {}; st_q = {}; exp_st = {};
  endtask

  initial begin
    bq_t fa, fb, kv;
    int n, nw, ew;
    bit cor;
    logic [31:0] c;

    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      crc_tab[i] = c;
    end

    reset = 1'b1; start_i = 1'b0; valid_i = 1'b0; last_i = 1'b0; err_i = 1'b0;
    data_i = 32'h0; len_i = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst:valid_o", 32'(valid_o), 32'd0);
    chk("rst:data_o", data_o, 32'd0);
    chk("rst:last_o", 32'(last_o), 32'd0);
    chk("rst:done_o", 32'(done_o), 32'd0);
    chk("rst:fcs_ok_o", 32'(fcs_ok_o), 32'd0);
    chk("rst:flags", {27'd0, runt_o, oversize_o, abort_o, pcs_err_o, 1'b0}, 32'd0);
    chk("rst:frame_len_o", 32'(frame_len_o), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    out_q = {}; st_q = {};

    // Known "123456789" frame with its FCS.
    kv = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
          8'h26, 8'h39, 8'hF4, 8'hCB};
    send_frame(kv, 0, 99, 1'b1, 0, 0, -1);
    drain();
    chk("kv:count", 32'(out_q.size()), 32'd3);
    if (out_q.size() == 3) begin
      chk("kv:w0", out_q[0].data, 32'h3433_3231);
      chk("kv:w2", out_q[2].data, 32'h0000_0039);
      chk("kv:w2_len", 32'(out_q[2].len), 32'd0);
    end
    if (st_q.size() == 1) chk("kv:fcs_ok", 32'(st_q[0].fcs_ok), 32'd1);
    expect_frame(kv, 1'b0);
    compare_all("kv");

    kv[4] = 8'h75;
    send_frame(kv, 0, 99, 1'b1, 0, 0, -1);
    drain();
    if (st_q.size() == 1) chk("kv_bad:fcs_ok", 32'(st_q[0].fcs_ok), 32'd0);
    expect_frame(kv, 1'b0);
    compare_all("kv_bad");

    make_frame(64, 1'b0, fa);
    send_frame(fa, 0, 99, 1'b1, 1, 3, -1);
    drain();
    expect_frame(fa, 1'b0);
    compare_all("len64_gaps");

    make_frame(1519, 1'b0, fa);
    send_frame(fa, 0, 999, 1'b1, 0, 0, -1);
    drain();
    expect_frame(fa, 1'b0);
    compare_all("len1519");
    make_frame(1518, 1'b0, fa);
    send_frame(fa, 0, 999, 1'b1, 0, 1, -1);
    drain();
    expect_frame(fa, 1'b0);
    compare_all("len1518");

    make_frame(4, 1'b0, fa);
    send_frame(fa, 0, 99, 1'b1, 0, 0, -1);
    make_frame(2, 1'b0, fb);
    send_frame(fb, 0, 99, 1'b1, 0, 0, -1);
    drain();
    expect_frame(fa, 1'b0);
    expect_frame(fb, 1'b0);
    compare_all("single_word");

    // Frame A cut by a new start after 5 words; B good, then C with a PCS error.
    make_frame(40, 1'b0, fa);
    send_frame(fa, 0, 5, 1'b1, 0, 1, -1);
    make_frame(70, 1'b0, fb);
    send_frame(fb, 0, 99, 1'b1, 0, 2, -1);
    expect_abort(fa, 5);
    expect_frame(fb, 1'b0);
    make_frame(50, 1'b0, fa);
    send_frame(fa, 0, 99, 1'b1, 0, 1, 2);
    drain();
    expect_frame(fa, 1'b1);
    compare_all("abort_err");

    make_frame(40, 1'b0, fa);
    send_frame(fa, 0, 3, 1'b1, 0, 0, -1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst:valid_o", 32'(valid_o), 32'd0);
    chk("mid_rst:done_o", 32'(done_o), 32'd0);
    reset = 1'b0;
    send_frame(fa, 3, 99, 1'b0, 0, 1, -1);
    drain();
    expect_partial(fa, 3);
    compare_all("mid_rst");
    make_frame(80, 1'b0, fb);
    send_frame(fb, 0, 99, 1'b1, 0, 1, -1);
    drain();
    expect_frame(fb, 1'b0);
    compare_all("after_rst");

    for (int f = 0; f < 10; f++) begin
      n   = $urandom_range(1, 200);
      nw  = (n + 3) / 4;
      cor = ($urandom_range(0, 3) == 0);
      ew  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nw - 1) : -1;
      make_frame(n, cor, fa);
      send_frame(fa, 0, 999, 1'b1, 0, 2, ew);
      expect_frame(fa, ew >= 0);
    end
    drain();
    compare_all("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
